axi_read_slave_port: RTL and testbench

- AXI4 read-side responder at the slave end of the interconnect's read address/read data channels.
- Accepts one AR request at a time from the interconnect, using the 8-bit slave-side ID.
- Fetches each beat from a single-port synchronous SRAM with 1-cycle read latency and returns the burst on the R channel.
- Used as the read front-end of the memory slaves (IM/DM/ROM wrappers). Write channels live in a separate block.

---
 rtl/axi_pkg.sv | 46 ++++
 rtl/axi_read_slave_port_if.sv | 30 +++
 rtl/axi_burst_addr_gen.sv | 37 +++
 rtl/axi_read_slave_port.sv | 150 +++++++++++++++
 tb/tb_axi_read_slave_port.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: channel widths, burst/resp encodings, read FSM states.
package axi_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_IDS_W   = 8;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;

  // Largest beat size a 32-bit data bus can carry (log2 bytes).
  localparam logic [AXI_SIZE_W-1:0] AXI_MAX_SIZE = AXI_SIZE_W'(2);

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_RESP
  } rd_state_e;

  // Latched read-address request.
  typedef struct packed {
    logic [AXI_IDS_W-1:0]   id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } ar_req_t;

  // Beat sizes wider than the data bus are answered with SLVERR.
  function automatic logic size_err(input logic [AXI_SIZE_W-1:0] size);
    return size > AXI_MAX_SIZE;
  endfunction

endpackage

// File: rtl/axi_read_slave_port_if.sv
// Slave-side AXI read address / read data channels.
interface axi_read_slave_port_if;
  import axi_pkg::*;

  logic [AXI_IDS_W-1:0]   ARID_S;
  logic [AXI_ADDR_W-1:0]  ARADDR_S;
  logic [AXI_LEN_W-1:0]   ARLEN_S;
  logic [AXI_SIZE_W-1:0]  ARSIZE_S;
  logic [AXI_BURST_W-1:0] ARBURST_S;
  logic                   ARVALID_S;
  logic                   ARREADY_S;

  logic [AXI_IDS_W-1:0]   RID_S;
  logic [AXI_DATA_W-1:0]  RDATA_S;
  logic [AXI_RESP_W-1:0]  RRESP_S;
  logic                   RLAST_S;
  logic                   RVALID_S;
  logic                   RREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat byte address for FIXED / INCR / WRAP bursts (reserved encoding acts as INCR).
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  addr,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_ADDR_W-1:0]  next_addr_c
);

  logic [AXI_ADDR_W-1:0] inc;
  logic [AXI_ADDR_W-1:0] incr_addr;
  logic [AXI_ADDR_W-1:0] wrap_bytes;
  logic [AXI_ADDR_W-1:0] wrap_mask;
  logic                  wrap_ok;

  // Wrap is legal only for 2/4/8/16-beat bursts; anything else degrades to INCR.
  always_comb begin
    inc        = AXI_ADDR_W'(1) << size;
    incr_addr  = addr + inc;
    wrap_ok    = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    wrap_bytes = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
    wrap_mask  = wrap_bytes - AXI_ADDR_W'(1);
    next_addr_c = incr_addr;
    case (burst)
      BURST_FIXED: next_addr_c = addr;
      BURST_WRAP: begin
        if (wrap_ok) begin
          next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
      end
      default: next_addr_c = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_slave_port.sv
// AXI4 read responder: one outstanding burst, each beat fetched from a 1-cycle SRAM.
module axi_read_slave_port
  import axi_pkg::*;
#(
  parameter int unsigned MEM_AW = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_read_slave_port_if.slave  rd,
  output logic                  mem_cs,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  rd_state_e state;
  rd_state_e state_d;

  ar_req_t               req;
  logic                  err;
  logic [AXI_LEN_W-1:0]  beat_cnt;

  logic [AXI_IDS_W-1:0]  rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_RESP_W-1:0] rresp;
  logic                  rlast;
  logic                  rvalid;

  logic                  ar_load;
  logic                  beat_load;
  logic                  beat_adv;
  logic                  beat_done;
  logic [AXI_ADDR_W-1:0] next_addr;
  logic [AXI_ADDR_W-1:0] fetch_addr;
  logic                  unused_fetch_bits;

  axi_burst_addr_gen u_addr_gen (
    .addr        (req.addr),
    .size        (req.size),
    .len         (req.len),
    .burst       (req.burst),
    .next_addr_c (next_addr)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= RD_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, datapath strobes and the same-cycle SRAM fetch.
  always_comb begin
    state_d    = state;
    ar_load    = 1'b0;
    beat_load  = 1'b0;
    beat_adv   = 1'b0;
    beat_done  = 1'b0;
    mem_cs     = 1'b0;
    fetch_addr = '0;
    case (state)
      RD_IDLE: begin
        if (rd.ARVALID_S) begin
          ar_load = 1'b1;
          state_d = RD_FETCH;
          if (!size_err(rd.ARSIZE_S)) begin
            mem_cs     = 1'b1;
            fetch_addr = rd.ARADDR_S;
          end
        end
      end
      RD_FETCH: begin
        beat_load = 1'b1;
        state_d   = RD_RESP;
      end
      RD_RESP: begin
        if (rvalid && rd.RREADY_S) begin
          if (rlast) begin
            beat_done = 1'b1;
            state_d   = RD_IDLE;
          end else begin
            beat_adv = 1'b1;
            state_d  = RD_FETCH;
            if (!err) begin
              mem_cs     = 1'b1;
              fetch_addr = next_addr;
            end
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Request latch and beat counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      req      <= '0;
      err      <= 1'b0;
      beat_cnt <= '0;
    end else if (ar_load) begin
      req.id    <= rd.ARID_S;
      req.addr  <= rd.ARADDR_S;
      req.len   <= rd.ARLEN_S;
      req.size  <= rd.ARSIZE_S;
      req.burst <= rd.ARBURST_S;
      err       <= size_err(rd.ARSIZE_S);
      beat_cnt  <= '0;
    end else if (beat_adv) begin
      req.addr <= next_addr;
      beat_cnt <= beat_cnt + AXI_LEN_W'(1);
    end
  end

  // R channel registers; held stable while the master stalls.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rid    <= '0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
    end else if (beat_load) begin
      rid    <= req.id;
      rdata  <= err ? '0 : AXI_DATA_W'(mem_rdata);
      rresp  <= err ? RESP_SLVERR : RESP_OKAY;
      rlast  <= (beat_cnt == req.len);
      rvalid <= 1'b1;
    end else if (beat_adv) begin
      rvalid <= 1'b0;
    end else if (beat_done) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end
  end

  // Upper address bits are decoded by the interconnect; the low two select a byte lane.
  assign mem_addr          = fetch_addr[MEM_AW+1:2];
  assign unused_fetch_bits = ^{fetch_addr[AXI_ADDR_W-1:MEM_AW+2], fetch_addr[1:0]};

  assign rd.ARREADY_S = (state == RD_IDLE);
  assign rd.RID_S     = rid;
  assign rd.RDATA_S   = rdata;
  assign rd.RRESP_S   = rresp;
  assign rd.RLAST_S   = rlast;
  assign rd.RVALID_S  = rvalid;

endmodule

// File: tb/tb_axi_read_slave_port.sv
// Randomised bench for axi_read_slave_port with a closed-form burst model.
`timescale 1ns/1ps
module tb_axi_read_slave_port;
  import axi_pkg::*;

  localparam int unsigned MEM_AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_read_slave_port_if bus();
  logic              mem_cs;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = 32'h0;

  axi_read_slave_port #(.MEM_AW(MEM_AW), .DATA_W(32)) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .rd        (bus),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // SRAM contents are a fixed function of the word address.
  function automatic logic [31:0] sram_word(input logic [MEM_AW-1:0] a);
    return 32'hC3A5_0000 ^ (32'(a) * 32'h0001_0011) ^ {18'h0, a};
  endfunction

  always @(posedge clk) if (mem_cs) mem_rdata <= sram_word(mem_addr);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Byte address of beat k, computed directly from the start address.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst,
                                            input int k);
    logic [31:0] inc, wb, base;
    inc = 32'd1 << size;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      wb   = (32'(len) + 32'd1) * inc;
      base = start - (start % wb);
      return base + (((start - base) + 32'(k) * inc) % wb);
    end
    return start + 32'(k) * inc;
  endfunction

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t             exp_q[$];
  logic [MEM_AW-1:0] fetch_q[$];
  logic [MEM_AW-1:0] last_words[$];
  logic [MEM_AW-1:0] obs_words[$];
  bit   busy = 0;
  bit   first_pending = 0;
  bit   gap = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cs_cnt = 0;
  int   cs_exp = 0;
  int   pops = 0;
  int   last_seen = 0;
  logic [7:0] last_rid = 8'h0;

  task automatic model_accept();
    logic        e;
    logic [31:0] a;
    beat_t       b;
    e = bus.ARSIZE_S > 3'd2;
    busy = 1; acc_cyc = cyc; first_pending = 1; cs_cnt = 0;
    obs_words.delete(); last_words.delete();
    cs_exp = e ? 0 : int'(bus.ARLEN_S) + 1;
    for (int k = 0; k <= int'(bus.ARLEN_S); k++) begin
      a = beat_addr(bus.ARADDR_S, bus.ARSIZE_S, bus.ARLEN_S, bus.ARBURST_S, k);
      b.id   = bus.ARID_S;
      b.resp = e ? 2'b10 : 2'b00;
      b.data = e ? 32'h0 : sram_word(a[MEM_AW+1:2]);
      b.last = (k == int'(bus.ARLEN_S));
      exp_q.push_back(b);
      if (!e) begin
        fetch_q.push_back(a[MEM_AW+1:2]);
        last_words.push_back(a[MEM_AW+1:2]);
      end
    end
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    beat_t f;
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); fetch_q.delete();
      busy = 0; gap = 0; first_pending = 0;
    end else begin
      chk("arready", 64'(bus.ARREADY_S), 64'(!busy));
      if (bus.ARVALID_S && bus.ARREADY_S && !busy) model_accept();
      if (bus.RVALID_S && !bus.RREADY_S) chk("cs_while_stalled", 64'(mem_cs), 64'(0));
      if (mem_cs) begin
        cs_cnt++;
        obs_words.push_back(mem_addr);
        if (fetch_q.size() == 0) chk("cs_unexpected", 64'(mem_cs), 64'(0));
        else chk("mem_addr", 64'(mem_addr), 64'(fetch_q.pop_front()));
      end
      if (gap) begin
        chk("beat_gap_rvalid", 64'(bus.RVALID_S), 64'(0));
        gap = 0;
      end
      if (bus.RVALID_S) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", 64'(bus.RVALID_S), 64'(0));
        else begin
          f = exp_q[0];
          if (first_pending) begin
            chk("first_latency", 64'(cyc - acc_cyc), 64'(2));
            first_pending = 0;
          end
          chk("rid", 64'(bus.RID_S), 64'(f.id));
          chk("rdata", 64'(bus.RDATA_S), 64'(f.data));
          chk("rresp", 64'(bus.RRESP_S), 64'(f.resp));
          chk("rlast", 64'(bus.RLAST_S), 64'(f.last));
          if (bus.RREADY_S) begin
            void'(exp_q.pop_front());
            pops++;
            gap = 1;
            last_rid = f.id;
            if (f.last) begin
              busy = 0;
              last_seen++;
            end
          end
        end
      end
    end
  end

  // RREADY policy: 0 always ready, 1 random, 2 two stall cycles per beat.
  int rmode = 0;
  int vcnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus.RVALID_S) vcnt++;
    else vcnt = 0;
    case (rmode)
      0:       bus.RREADY_S = 1'b1;
      1:       bus.RREADY_S = 1'($urandom_range(0, 1));
      default: bus.RREADY_S = (vcnt >= 3);
    endcase
  end

  // Present a request and hold it until the slave takes it.
  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 0;
    bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
    bus.ARSIZE_S = size; bus.ARBURST_S = burst; bus.ARVALID_S = 1'b1;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (bus.ARREADY_S && rst_n) begin
        done = 1;
        @(posedge clk); #1;
        bus.ARVALID_S = 1'b0;
      end
    end
    if (!done) begin
      chk("ar_timeout", 64'(bus.ARREADY_S), 64'(1));
      bus.ARVALID_S = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 64'(busy), 64'(0));
    else chk("cs_pulses", 64'(cs_cnt), 64'(cs_exp));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int start_pops, start_last;
    bit got;
    logic [MEM_AW-1:0] lit[4];
    bus.ARVALID_S = 0; bus.ARID_S = 0; bus.ARADDR_S = 0; bus.ARLEN_S = 0;
    bus.ARSIZE_S = 0; bus.ARBURST_S = 0; bus.RREADY_S = 0;

    // Reset values.
    #12;
    chk("rst_arready", 64'(bus.ARREADY_S), 64'(1));
    chk("rst_rvalid", 64'(bus.RVALID_S), 64'(0));
    chk("rst_rid", 64'(bus.RID_S), 64'(0));
    chk("rst_mem_cs", 64'(mem_cs), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR.
    rmode = 0;
    send_ar(8'h13, 32'h0000_0010, 4'd3, 3'd2, 2'b01);
    lit[0] = 14'h4; lit[1] = 14'h5; lit[2] = 14'h6; lit[3] = 14'h7;
    for (int i = 0; i < 4; i++) chk("pin_incr_model", 64'(last_words[i]), 64'(lit[i]));
    wait_idle();
    chk("incr_cs_count", 64'(obs_words.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_words.size(); i++) chk("incr_mem_addr", 64'(obs_words[i]), 64'(lit[i]));
    chk("incr_rid", 64'(last_rid), 64'(8'h13));

    // WRAP.
    send_ar(8'h21, 32'h0000_0038, 4'd3, 3'd2, 2'b10);
    lit[0] = 14'hE; lit[1] = 14'hF; lit[2] = 14'hC; lit[3] = 14'hD;
    for (int i = 0; i < 4; i++) chk("pin_wrap_model", 64'(last_words[i]), 64'(lit[i]));
    wait_idle();
    for (int i = 0; i < 4 && i < obs_words.size(); i++) chk("wrap_mem_addr", 64'(obs_words[i]), 64'(lit[i]));

    // FIXED with backpressure.
    rmode = 2;
    send_ar(8'h35, 32'h0000_0020, 4'd2, 3'd2, 2'b00);
    wait_idle();
    chk("fixed_cs_count", 64'(obs_words.size()), 64'(3));
    for (int i = 0; i < obs_words.size(); i++) chk("fixed_mem_addr", 64'(obs_words[i]), 64'(14'h8));

    // Oversized beat -> SLVERR, no SRAM access.
    rmode = 0;
    send_ar(8'h44, 32'h0000_0100, 4'd1, 3'd3, 2'b01);
    wait_idle();
    chk("err_no_cs", 64'(obs_words.size()), 64'(0));

    // Back-to-back: second request held while the first is outstanding.
    send_ar(8'hA1, 32'h0000_0100, 4'd3, 3'd2, 2'b01);
    send_ar(8'hB2, 32'h0000_0200, 4'd0, 3'd2, 2'b01);
    wait_idle();
    chk("b2b_second_id", 64'(last_rid), 64'(8'hB2));

    // Reset mid-burst.
    start_pops = pops;
    send_ar(8'h5C, 32'h0000_0400, 4'd15, 3'd2, 2'b01);
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(posedge clk); #1;
      if (pops - start_pops >= 5) got = 1;
    end
    chk("reset_reach_beat5", 64'(got), 64'(1));
    #1; rst_n = 1'b0; #1;
    chk("midrst_rvalid", 64'(bus.RVALID_S), 64'(0));
    chk("midrst_arready", 64'(bus.ARREADY_S), 64'(1));
    chk("midrst_rlast", 64'(bus.RLAST_S), 64'(0));
    chk("midrst_mem_cs", 64'(mem_cs), 64'(0));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    start_last = last_seen;
    send_ar(8'h66, 32'h0000_0044, 4'd0, 3'd2, 2'b01);
    wait_idle();
    chk("post_reset_single_last", 64'(last_seen - start_last), 64'(1));
    chk("post_reset_rid", 64'(last_rid), 64'(8'h66));

    // Random bursts.
    for (int n = 0; n < 40; n++) begin
      rmode = $urandom_range(0, 2);
      send_ar(8'($urandom), 32'($urandom), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
